// File: rtl/rx_udp_filter.sv
// rx_udp_filter: UDP header parser and destination-port filter on the IPv4 receive byte stream.
// Optional build macro RX_UDP_CSUM_EN adds UDP checksum verification (error code 11 on failure).
module rx_udp_filter #(
  parameter int unsigned OCT     = 8,
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                     RX_CLK,
  input  logic                     rst_n,
  input  logic                     func_en,
  input  logic [N_PORTS*OCT*2-1:0] port_tbl,
  input  logic [N_PORTS-1:0]       port_en,
  input  logic                     rx_ipv4_data_v,
  input  logic [OCT-1:0]           rx_ipv4_data,
  input  logic [15:0]              rx_pseudo_sum,
  output logic                     rx_udp_data_v,
  output logic [OCT-1:0]           rx_udp_data,
  output logic                     rx_udp_last,
  output logic [OCT*2-1:0]         rx_src_port,
  output logic [OCT*2-1:0]         rx_dst_port,
  output logic [OCT*2-1:0]         rx_data_len,
  output logic [IDX_W-1:0]         rx_port_idx,
  output logic                     rx_udp_irq,
  output logic                     rx_udp_err,
  output logic [1:0]               rx_err_code,
  output logic [15:0]              rx_drop_cnt
);

  localparam int unsigned FW = OCT * 2;
  localparam int unsigned CW = 16;
  localparam logic [1:0]    ST_GOOD   = 2'b00;
  localparam logic [1:0]    ERR_LEN   = 2'b01;
  localparam logic [1:0]    ERR_TRUNC = 2'b10;
  localparam logic [1:0]    ERR_CSUM  = 2'b11;
  localparam logic [FW-1:0] HDR_LEN   = FW'(8);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    DRAIN   = 3'd3,
    STAT    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       hcnt_q, hcnt_d;
  logic [OCT-1:0]   hi_q, hi_d;
  logic             hit_q, hit_d;
  logic [1:0]       pend_q, pend_d;
  logic             report_q, report_d;
  logic [FW-1:0]    pcnt_q, pcnt_d;
  logic [FW-1:0]    src_q, src_d;
  logic [FW-1:0]    dst_q, dst_d;
  logic [FW-1:0]    len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dv_q, dv_d;
  logic [OCT-1:0]   data_q, data_d;
  logic             last_q, last_d;
  logic             irq_q, irq_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [15:0]      drop_q, drop_d;

  logic             start;
  logic [FW-1:0]    field_now;
  logic             hit_now;
  logic [IDX_W-1:0] idx_now;
  logic [1:0]       fin_code;
  logic             fire;
  logic [1:0]       fire_code;

  // A datagram may begin in IDLE or directly in the status cycle of the previous one.
  assign start     = func_en && rx_ipv4_data_v && (state_q == IDLE || state_q == STAT);
  assign field_now = {hi_q, rx_ipv4_data};

  // Port match on the completing dst field; the first enabled hit from index 0 wins.
  always_comb begin
    hit_now = 1'b0;
    idx_now = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (!hit_now && port_en[i] && (port_tbl[i*int'(FW) +: FW] == field_now)) begin
        hit_now = 1'b1;
        idx_now = IDX_W'(i);
      end
    end
  end

`ifdef RX_UDP_CSUM_EN
  logic [CW-1:0] sum_q, sum_d;
  logic [CW-1:0] ck_q, ck_d;
  logic [CW-1:0] byte_word;
  logic [CW-1:0] sum_next;
  logic [CW-1:0] ck_now;
  logic          byte_odd;

  function automatic logic [CW-1:0] csum_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW-1:0] + CW'(s[CW]);
  endfunction

  // Even datagram offsets are the high half of a 16-bit word, odd offsets the low half.
  always_comb begin
    sum_d     = sum_q;
    ck_d      = ck_q;
    byte_odd  = (state_q == PAYLOAD) ? pcnt_q[0] : hcnt_q[0];
    byte_word = byte_odd ? CW'(rx_ipv4_data) : CW'({rx_ipv4_data, OCT'(0)});
    sum_next  = csum_add(sum_q, byte_word);
    ck_now    = (state_q == HDR) ? CW'(field_now) : ck_q;
    fin_code  = ((sum_next == 16'hFFFF) || (ck_now == '0)) ? ST_GOOD : ERR_CSUM;
    if (start) begin
      sum_d = csum_add(rx_pseudo_sum, CW'({rx_ipv4_data, OCT'(0)}));
    end else if (func_en && rx_ipv4_data_v && (state_q == HDR || state_q == PAYLOAD)) begin
      sum_d = sum_next;
    end
    if (func_en && rx_ipv4_data_v && state_q == HDR && hcnt_q == 3'd7) begin
      ck_d = CW'(field_now);
    end
  end

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      ck_q  <= '0;
    end else begin
      sum_q <= sum_d;
      ck_q  <= ck_d;
    end
  end
`else
  logic unused_pseudo;
  assign unused_pseudo = ^rx_pseudo_sum;
  assign fin_code      = ST_GOOD;
`endif

  // Next-state and registered-output logic; status pulses are raised on entry to STAT.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    hi_d      = hi_q;
    hit_d     = hit_q;
    pend_d    = pend_q;
    report_d  = report_q;
    pcnt_d    = pcnt_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    idx_d     = idx_q;
    data_d    = data_q;
    code_d    = code_q;
    drop_d    = drop_q;
    dv_d      = 1'b0;
    last_d    = 1'b0;
    irq_d     = 1'b0;
    err_d     = 1'b0;
    fire      = 1'b0;
    fire_code = ST_GOOD;

    if (!func_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, STAT: begin
          state_d = IDLE;
          if (start) begin
            state_d = HDR;
            hcnt_d  = 3'd1;
            hi_d    = rx_ipv4_data;
            hit_d   = 1'b0;
          end
        end

        HDR: begin
          if (!rx_ipv4_data_v) begin
            // Truncated header: only report once the destination port is known.
            if (hcnt_q >= 3'd4) begin
              state_d   = STAT;
              fire      = hit_q;
              fire_code = ERR_TRUNC;
            end else begin
              state_d = IDLE;
            end
          end else begin
            hcnt_d = hcnt_q + 3'd1;
            if (!hcnt_q[0]) begin
              hi_d = rx_ipv4_data;
            end else begin
              case (hcnt_q[2:1])
                2'd0: src_d = field_now;
                2'd1: begin
                  dst_d = field_now;
                  hit_d = hit_now;
                  if (hit_now) idx_d = idx_now;
                end
                2'd2: len_d = field_now;
                default: begin
                  if (len_q < HDR_LEN) begin
                    state_d  = DRAIN;
                    pend_d   = ERR_LEN;
                    report_d = hit_q;
                  end else if (!hit_q) begin
                    state_d  = DRAIN;
                    report_d = 1'b0;
                    if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                  end else if (len_q == HDR_LEN) begin
                    state_d   = STAT;
                    fire      = 1'b1;
                    fire_code = fin_code;
                  end else begin
                    state_d = PAYLOAD;
                    pcnt_d  = HDR_LEN;
                  end
                end
              endcase
            end
          end
        end

        PAYLOAD: begin
          if (!rx_ipv4_data_v) begin
            state_d   = STAT;
            fire      = 1'b1;
            fire_code = ERR_TRUNC;
          end else begin
            dv_d   = 1'b1;
            data_d = rx_ipv4_data;
            pcnt_d = pcnt_q + FW'(1);
            if (pcnt_q == len_q - FW'(1)) begin
              last_d   = 1'b1;
              state_d  = DRAIN;
              pend_d   = fin_code;
              report_d = 1'b1;
            end
          end
        end

        DRAIN: begin
          if (!rx_ipv4_data_v) begin
            state_d   = STAT;
            fire      = report_q;
            fire_code = pend_q;
          end
        end

        default: state_d = IDLE;
      endcase

      if (fire) begin
        if (fire_code == ST_GOOD) begin
          irq_d = 1'b1;
        end else begin
          err_d  = 1'b1;
          code_d = fire_code;
        end
      end
    end
  end

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      hi_q     <= '0;
      hit_q    <= 1'b0;
      pend_q   <= '0;
      report_q <= 1'b0;
      pcnt_q   <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      dv_q     <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      hi_q     <= hi_d;
      hit_q    <= hit_d;
      pend_q   <= pend_d;
      report_q <= report_d;
      pcnt_q   <= pcnt_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      dv_q     <= dv_d;
      data_q   <= data_d;
      last_q   <= last_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
      code_q   <= code_d;
      drop_q   <= drop_d;
    end
  end

  assign rx_udp_data_v = dv_q;
  assign rx_udp_data   = data_q;
  assign rx_udp_last   = last_q;
  assign rx_src_port   = src_q;
  assign rx_dst_port   = dst_q;
  assign rx_data_len   = len_q;
  assign rx_port_idx   = idx_q;
  assign rx_udp_irq    = irq_q;
  assign rx_udp_err    = err_q;
  assign rx_err_code   = code_q;
  assign rx_drop_cnt   = drop_q;

endmodule

// File: tb/tb_rx_udp_filter.sv
// Directed bench for rx_udp_filter: expected payload bytes and status pulses are queued at
// stimulus time and matched by an independent monitor, including output cycle.
module tb_rx_udp_filter;

  logic        RX_CLK = 1'b0;
  logic        rst_n;
  logic        func_en;
  logic [63:0] port_tbl;
  logic [3:0]  port_en;
  logic        rx_ipv4_data_v;
  logic [7:0]  rx_ipv4_data;
  logic [15:0] rx_pseudo_sum;
  logic        rx_udp_data_v;
  logic [7:0]  rx_udp_data;
  logic        rx_udp_last;
  logic [15:0] rx_src_port;
  logic [15:0] rx_dst_port;
  logic [15:0] rx_data_len;
  logic [1:0]  rx_port_idx;
  logic        rx_udp_irq;
  logic        rx_udp_err;
  logic [1:0]  rx_err_code;
  logic [15:0] rx_drop_cnt;

  rx_udp_filter #(.OCT(8), .N_PORTS(4), .IDX_W(2)) dut (
    .RX_CLK        (RX_CLK),
    .rst_n         (rst_n),
    .func_en       (func_en),
    .port_tbl      (port_tbl),
    .port_en       (port_en),
    .rx_ipv4_data_v(rx_ipv4_data_v),
    .rx_ipv4_data  (rx_ipv4_data),
    .rx_pseudo_sum (rx_pseudo_sum),
    .rx_udp_data_v (rx_udp_data_v),
    .rx_udp_data   (rx_udp_data),
    .rx_udp_last   (rx_udp_last),
    .rx_src_port   (rx_src_port),
    .rx_dst_port   (rx_dst_port),
    .rx_data_len   (rx_data_len),
    .rx_port_idx   (rx_port_idx),
    .rx_udp_irq    (rx_udp_irq),
    .rx_udp_err    (rx_udp_err),
    .rx_err_code   (rx_err_code),
    .rx_drop_cnt   (rx_drop_cnt)
  );

  always #5 RX_CLK = ~RX_CLK;

  int cyc = 0;
  always @(posedge RX_CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } dexp_t;

  typedef struct {
    logic       err;
    logic [1:0] code;
    int         cyc;
  } sexp_t;

  dexp_t      dq[$];
  sexp_t      sq[$];
  logic [7:0] pkt[$];
  int         vectors     = 0;
  int         miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event must match the head of its expectation queue.
  always @(negedge RX_CLK) begin
    dexp_t de;
    sexp_t se;
    if (rx_udp_data_v) begin
      if (dq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_data: got 0x%0h, expected no output (cycle %0d)", rx_udp_data, cyc);
      end else begin
        de = dq.pop_front();
        check("data_byte", 64'(rx_udp_data), 64'(de.data));
        check("data_last", 64'(rx_udp_last), 64'(de.last));
        check("data_cycle", 64'(cyc), 64'(de.cyc));
      end
    end else if (rx_udp_last) begin
      vectors++;
      miscompares++;
      $display("FAIL last_without_valid: got last=1, expected 0 (cycle %0d)", cyc);
    end
    if (rx_udp_irq || rx_udp_err) begin
      if (sq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_status: got irq=%0b err=%0b, expected none (cycle %0d)",
                 rx_udp_irq, rx_udp_err, cyc);
      end else begin
        se = sq.pop_front();
        check("status_kind", 64'({rx_udp_err, rx_udp_irq}), 64'(se.err ? 2'b10 : 2'b01));
        if (se.err) check("err_code", 64'(rx_err_code), 64'(se.code));
        check("status_cycle", 64'(cyc), 64'(se.cyc));
      end
    end
  end

  task automatic mk_hdr(input logic [15:0] src, input logic [15:0] dst,
                        input logic [15:0] len, input logic [15:0] ck);
    pkt.delete();
    pkt.push_back(src[15:8]);
    pkt.push_back(src[7:0]);
    pkt.push_back(dst[15:8]);
    pkt.push_back(dst[7:0]);
    pkt.push_back(len[15:8]);
    pkt.push_back(len[7:0]);
    pkt.push_back(ck[15:8]);
    pkt.push_back(ck[7:0]);
  endtask

  // Drive pkt back to back; bytes [fwd_lo, fwd_lo+fwd_n) are expected one cycle later.
  // st: 0 no status, 1 irq, 2 err with code.
  task automatic send(input int fwd_lo, input int fwd_n, input bit last_exp,
                      input int st, input logic [1:0] code);
    dexp_t e;
    sexp_t s;
    for (int k = 0; k < pkt.size(); k++) begin
      @(negedge RX_CLK);
      rx_ipv4_data_v = 1'b1;
      rx_ipv4_data   = pkt[k];
      if (k >= fwd_lo && k < fwd_lo + fwd_n) begin
        e.data = pkt[k];
        e.last = last_exp && (k == fwd_lo + fwd_n - 1);
        e.cyc  = cyc + 1;
        dq.push_back(e);
      end
    end
    @(negedge RX_CLK);
    rx_ipv4_data_v = 1'b0;
    rx_ipv4_data   = 8'h00;
    if (st != 0) begin
      s.err  = (st == 2);
      s.code = code;
      s.cyc  = cyc + 1;
      sq.push_back(s);
    end
    repeat (4) @(negedge RX_CLK);
    check("data_queue_drained", 64'(dq.size()), 64'(0));
    check("status_queue_drained", 64'(sq.size()), 64'(0));
  endtask

  task automatic check_zero(input string name);
    check({name, "_hdr"}, 64'({rx_src_port, rx_dst_port, rx_data_len}), 64'(0));
    check({name, "_ctl"}, 64'({rx_udp_data_v, rx_udp_data, rx_udp_last, rx_port_idx,
                               rx_udp_irq, rx_udp_err, rx_err_code, rx_drop_cnt}), 64'(0));
  endtask

  task automatic mk_a(input logic [15:0] ck, input logic [7:0] b3);
    mk_hdr(16'h1000, 16'h1234, 16'd12, ck);
    pkt.push_back(8'hDE);
    pkt.push_back(8'hAD);
    pkt.push_back(8'hBE);
    pkt.push_back(b3);
  endtask

  initial begin
    dexp_t e;
    rst_n          = 1'b0;
    func_en        = 1'b1;
    port_tbl       = {16'hABCD, 16'h0BAD, 16'hABCD, 16'h1234};
    port_en        = 4'b0001;
    rx_ipv4_data_v = 1'b0;
    rx_ipv4_data   = 8'h00;
    rx_pseudo_sum  = 16'h1111;
    repeat (2) @(negedge RX_CLK);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge RX_CLK);

    // Matched datagram, 4 payload bytes, no padding.
    mk_a(16'h0000, 8'hEF);
    send(8, 4, 1'b1, 1, 2'b00);
    check("t1_idx", 64'(rx_port_idx), 64'(0));
    check("t1_src", 64'(rx_src_port), 64'h1000);
    check("t1_dst", 64'(rx_dst_port), 64'h1234);
    check("t1_len", 64'(rx_data_len), 64'd12);

    // Unmatched destination is dropped and counted.
    check("t2_drop_before", 64'(rx_drop_cnt), 64'(0));
    mk_hdr(16'h1000, 16'h5678, 16'd12, 16'h0000);
    pkt.push_back(8'hDE); pkt.push_back(8'hAD); pkt.push_back(8'hBE); pkt.push_back(8'hEF);
    send(0, 0, 1'b0, 0, 2'b00);
    check("t2_drop_after", 64'(rx_drop_cnt), 64'(1));

    // Length 10 with six padding bytes.
    mk_hdr(16'h1000, 16'h1234, 16'd10, 16'h0000);
    pkt.push_back(8'h11);
    pkt.push_back(8'h22);
    for (int k = 0; k < 6; k++) pkt.push_back(8'hAA);
    send(8, 2, 1'b1, 1, 2'b00);

    // Truncated in payload after 4 of 12 payload bytes.
    mk_hdr(16'h1000, 16'h1234, 16'd20, 16'h0000);
    for (int k = 1; k <= 4; k++) pkt.push_back(8'(k));
    send(8, 4, 1'b0, 2, 2'b10);

    // Length below header size, two matching entries: lowest index reported.
    port_en = 4'b1111;
    mk_hdr(16'h3000, 16'hABCD, 16'd6, 16'h0000);
    send(0, 0, 1'b0, 2, 2'b01);
    check("t5_idx", 64'(rx_port_idx), 64'(1));
    check("t5_len", 64'(rx_data_len), 64'd6);

    // Header cut before the destination port completes: silent.
    mk_hdr(16'h2000, 16'hABCD, 16'h0030, 16'h0000);
    pkt = pkt[0:2];
    send(0, 0, 1'b0, 0, 2'b00);
    check("t6_drop", 64'(rx_drop_cnt), 64'(1));

    // Header cut after the destination port completes: truncation error.
    mk_hdr(16'h2000, 16'hABCD, 16'h0030, 16'h0000);
    pkt = pkt[0:5];
    send(0, 0, 1'b0, 2, 2'b10);
    check("t7_dst", 64'(rx_dst_port), 64'hABCD);

    // Disabled block ignores traffic and holds its outputs.
    port_en = 4'b0001;
    func_en = 1'b0;
    mk_a(16'h0000, 8'hEF);
    send(0, 0, 1'b0, 0, 2'b00);
    check("t8_dst_hold", 64'(rx_dst_port), 64'hABCD);
    check("t8_len_hold", 64'(rx_data_len), 64'h0030);
    check("t8_drop_hold", 64'(rx_drop_cnt), 64'(1));
    func_en = 1'b1;
    @(negedge RX_CLK);

    // Checksum cases (pseudo sum 0x1111; 0x2F11 is the correct checksum for DE AD BE EF).
    mk_a(16'h2F11, 8'hEF);
    send(8, 4, 1'b1, 1, 2'b00);
    mk_a(16'h2F11, 8'hEE);
`ifdef RX_UDP_CSUM_EN
    send(8, 4, 1'b1, 2, 2'b11);
`else
    send(8, 4, 1'b1, 1, 2'b00);
`endif
    mk_a(16'h0000, 8'hEE);
    send(8, 4, 1'b1, 1, 2'b00);

    // Reset mid-payload aborts without status; next datagram decodes normally.
    mk_hdr(16'h1000, 16'h1234, 16'd20, 16'h0000);
    pkt.push_back(8'h55);
    pkt.push_back(8'h66);
    for (int k = 0; k < pkt.size(); k++) begin
      @(negedge RX_CLK);
      rx_ipv4_data_v = 1'b1;
      rx_ipv4_data   = pkt[k];
      if (k >= 8) begin
        e.data = pkt[k];
        e.last = 1'b0;
        e.cyc  = cyc + 1;
        dq.push_back(e);
      end
    end
    @(negedge RX_CLK);
    #2;
    rst_n          = 1'b0;
    rx_ipv4_data_v = 1'b0;
    rx_ipv4_data   = 8'h00;
    @(negedge RX_CLK);
    check_zero("midreset");
    check("midreset_queue", 64'(dq.size()), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge RX_CLK);
    mk_a(16'h0000, 8'hEF);
    send(8, 4, 1'b1, 1, 2'b00);
    check("t10_idx", 64'(rx_port_idx), 64'(0));
    check("t10_len", 64'(rx_data_len), 64'd12);
    check("t10_drop", 64'(rx_drop_cnt), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_udp_filter.md
# rx_udp_filter

Parametrised UDP receive parser and port filter for the Vthernet MAC receive path. It sits between the IPv4 receive stage and the user payload sink. It consumes the IPv4 payload byte stream, decodes the 8-byte UDP header and matches the destination port against a programmable table of `N_PORTS` entries. Payload of matching datagrams is forwarded with an end marker, followed by one status pulse per datagram: good, or error with a code.

## Interface
Parameters:
- `OCT`, 8: stream byte width in bits; header fields are `OCT*2` bits wide.
- `N_PORTS`, 4: number of destination-port match entries (1..16).
- `IDX_W`, 2: width of the match index; must satisfy `2**IDX_W >= N_PORTS`.

Ports:
- `RX_CLK` in 1: receive clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `func_en` in 1: block enable.
- `port_tbl` in `N_PORTS*OCT*2`: match table; entry i is `port_tbl[i*16 +: 16]`.
- `port_en` in `N_PORTS`: per-entry enable mask.
- `rx_ipv4_data_v` in 1: input byte valid; high for the whole IPv4 payload, low for at least 1 cycle between datagrams.
- `rx_ipv4_data` in `OCT`: input byte, network order.
- `rx_pseudo_sum` in 16: ones-complement pseudo-header sum from IPv4; stable while `rx_ipv4_data_v` is high.
- `rx_udp_data_v` out 1: payload byte valid.
- `rx_udp_data` out `OCT`: payload byte.
- `rx_udp_last` out 1: final payload byte of a good-length datagram.
- `rx_src_port`, `rx_dst_port`, `rx_data_len` out 16 each: header fields of the current or last datagram.
- `rx_port_idx` out `IDX_W`: lowest matching table index.
- `rx_udp_irq` out 1: one-cycle pulse, datagram received good.
- `rx_udp_err` out 1: one-cycle pulse, matched datagram failed.
- `rx_err_code` out 2: valid with `rx_udp_err`. 01 = length < 8, 10 = truncated, 11 = checksum.
- `rx_drop_cnt` out 16: saturating count of datagrams matching no enabled entry.

## Operation
- Reset: every output is 0 and the state is IDLE.
- `func_en` low: input is ignored, state returns to IDLE, `rx_udp_data_v`, `rx_udp_last`, `rx_udp_irq` and `rx_udp_err` are 0, and the other outputs hold their values.
- States: IDLE, HDR, PAYLOAD, DRAIN, STAT.
- IDLE → HDR on `rx_ipv4_data_v` high. That first byte is header byte 0.
- HDR: captures 8 bytes, MSB first, into src port, dst port, length and checksum.
- Match is computed on the byte where the dst port completes: hit when `port_en[i]` is set and the entry equals dst port; lowest i wins.
- After byte 7 of HDR:
  - length < 8 → DRAIN with pending error 01.
  - no hit → DRAIN and increment `rx_drop_cnt`, saturating at 0xFFFF.
  - length == 8 → STAT, good.
  - otherwise → PAYLOAD.
- PAYLOAD: forwards each input byte. A 16-bit counter starts at 8 and increments per byte. The byte where counter == length−1 carries `rx_udp_last` and the next state is DRAIN with a good status pending.
- DRAIN: discards the remaining bytes (Ethernet/IP padding) until `rx_ipv4_data_v` falls, then goes to STAT.
- `rx_ipv4_data_v` falling in HDR or PAYLOAD means truncation:
  - In PAYLOAD, the error is code 10.
  - In HDR before the dst port completes, there is no status pulse and no drop count.
  - In HDR after the dst port completes, a matched datagram gets code 10.
- STAT: emits exactly one `rx_udp_irq` or `rx_udp_err` pulse for matched datagrams (none for dropped ones), then returns to IDLE.
- A new `rx_ipv4_data_v` arriving in STAT is captured as header byte 0.

## Timing
- Payload latency is 1 cycle: an input byte accepted at cycle N appears on `rx_udp_data` at N+1.
- `rx_udp_last` coincides with the final `rx_udp_data_v`.
- Good status pulses 1 cycle after `rx_ipv4_data_v` falls. Padding therefore delays status, never payload.
- Truncation error pulses at M+1, where M is the first cycle with `rx_ipv4_data_v` low. `rx_udp_last` is never asserted for a truncated datagram.
- Header outputs update as each field completes. `rx_port_idx` is valid from the first payload byte until the next header.
- Asynchronous reset mid-datagram aborts it with no status pulse.

## Configuration
- `RX_UDP_CSUM_EN` defined:
  - Running 16-bit ones-complement sum of all UDP bytes, with bytes paired as high then low and an odd final byte padded with 0x00 low, plus `rx_pseudo_sum`.
  - End-around carry is applied every add.
  - Good requires the folded sum == 0xFFFF, or a received checksum of 0x0000.
  - Otherwise `rx_udp_err` fires with code 11 in place of `rx_udp_irq`.
- Not defined: checksum is not computed, code 11 is never produced, and status timing is unchanged.

## Test plan
- Table {0x1234 en, others off}, datagram dst 0x1234, length 12, payload DE AD BE EF, no padding → 4 bytes out at +1 cycle, `rx_udp_last` on EF, `rx_udp_irq` 1 cycle after valid falls, `rx_port_idx` = 0.
- Same datagram with dst 0x5678 → no `rx_udp_data_v`, no pulses, `rx_drop_cnt` 0 → 1.
- Length 10, payload 11 22 followed by 6 padding bytes → only 11 22 forwarded, last on 22, irq after the padding ends.
- Length 20 but valid drops after 4 payload bytes → 4 bytes out, no last, `rx_udp_err` with code 10.
- Length 6 → no payload, err code 01. Entries 1 and 3 both equal dst → `rx_port_idx` = 1.
- With `RX_UDP_CSUM_EN`: correct checksum → irq. One payload bit flipped → err code 11. Checksum 0x0000 → irq. Reset asserted mid-payload → all outputs 0, next datagram decoded normally.
